// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port and the memory bus
// for the unified-memory arbiter.
//   Fetch port : if_req, if_addr -> if_ack, if_rdata
//   Data port  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//   Memory bus : mem_addr, mem_wdata, mem_write_n, mem_read_n <- mem_rdata
// Modport slave is the arbiter side; modport master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write_n;
    logic              mem_read_n;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_addr, mem_wdata, mem_write_n, mem_read_n
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_addr, mem_wdata, mem_write_n, mem_read_n
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory (active-low strobes, acts on the
// falling edge) between the instruction-fetch port and the data port.
// Data has fixed priority; after BURST_LIMIT consecutive data grants made
// while fetch waits, fetch is granted once. Each access is IDLE->ACCESS->DONE.
// Ports:
//   clk      - rising-edge clock
//   proc_rst - asynchronous reset, active-high
//   bus      - mem_arbiter_if.slave (fetch port, data port, memory bus)
//   busy     - high whenever the sequencer is not in IDLE
module mem_arbiter #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int BURST_LIMIT = 4
) (
    input  logic           clk,
    input  logic           proc_rst,
    mem_arbiter_if.slave   bus,
    output logic           busy
);
    localparam logic [3:0] LIMIT = 4'(BURST_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_data_q, sel_data_d;
    logic              we_q, we_d;
    logic [3:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              write_n_q, write_n_d;
    logic              read_n_q, read_n_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              any_req;
    logic              pick_data;

    assign any_req   = bus.d_req | bus.if_req;
    // Data wins unless fetch is waiting and the data burst has hit its limit.
    assign pick_data = bus.d_req & ~(bus.if_req & (burst_q == LIMIT));

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            state_q     <= IDLE;
            sel_data_q  <= 1'b0;
            we_q        <= 1'b0;
            burst_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            write_n_q   <= 1'b1;
            read_n_q    <= 1'b1;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_data_q  <= sel_data_d;
            we_q        <= we_d;
            burst_q     <= burst_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            write_n_q   <= write_n_d;
            read_n_q    <= read_n_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data_d  = sel_data_q;
        we_d        = we_q;
        burst_d     = burst_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        write_n_d   = 1'b1;
        read_n_d    = 1'b1;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_data_d = pick_data;
                    if (pick_data) begin
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        we_d        = bus.d_we;
                        write_n_d   = ~bus.d_we;
                        read_n_d    = bus.d_we;
                        // Counts only grants that made fetch wait; saturates.
                        if (!bus.if_req)
                            burst_d = '0;
                        else if (burst_q != LIMIT)
                            burst_d = burst_q + 4'd1;
                    end else begin
                        mem_addr_d = bus.if_addr;
                        we_d       = 1'b0;
                        read_n_d   = 1'b0;
                        burst_d    = '0;
                    end
                end
            end
            ACCESS: begin
                // Memory updated mem_rdata on the falling edge inside ACCESS.
                if (sel_data_q) begin
                    d_ack_d = 1'b1;
                    if (!we_q) d_rdata_d = bus.mem_rdata;
                end else begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_write_n = write_n_q;
    assign bus.mem_read_n  = read_n_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// falling-edge 64x16 memory model.
module tb_mem_arbiter;
    logic clk;
    logic proc_rst;
    logic busy;
    int   passed;
    int   total;

    mem_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();

    mem_arbiter #(
        .ADDR_W(6),
        .DATA_W(16),
        .BURST_LIMIT(4)
    ) dut (
        .clk(clk),
        .proc_rst(proc_rst),
        .bus(bus),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten words read as a fixed pattern, mem[5]=16'h1234.
    logic [15:0] mem [64];
    bit          valid [64];

    function automatic logic [15:0] init_val(input logic [5:0] a);
        return (a == 6'd5) ? 16'h1234 : {10'h2A0, a};
    endfunction

    always @(negedge clk) begin
        if (!bus.mem_write_n) begin
            mem[bus.mem_addr]   <= bus.mem_wdata;
            valid[bus.mem_addr] <= 1'b1;
        end
        if (!bus.mem_read_n)
            bus.mem_rdata <= valid[bus.mem_addr] ? mem[bus.mem_addr]
                                                 : init_val(bus.mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("strobe_excl", 32'(bus.mem_write_n | bus.mem_read_n), 32'd1);
        check("ack_excl", 32'(bus.if_ack & bus.d_ack), 32'd0);
    endtask

    task automatic wait_ack(output bit is_d, output bit is_f);
        bit seen;
        seen = 1'b0;
        is_d = 1'b0;
        is_f = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.d_ack || bus.if_ack) begin
                seen = 1'b1;
                is_d = bus.d_ack;
                is_f = bus.if_ack;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        bit is_d, is_f;
        bit exp_d [10];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        passed = 0;
        total  = 0;

        proc_rst    = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_write_n", 32'(bus.mem_write_n), 32'd1);
        check("rst_read_n", 32'(bus.mem_read_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        check("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
        check("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        proc_rst = 1'b0;

        // Fetch only
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd5;
        tick();
        check("f_read_n", 32'(bus.mem_read_n), 32'd0);
        check("f_write_n", 32'(bus.mem_write_n), 32'd1);
        check("f_addr", 32'(bus.mem_addr), 32'd5);
        check("f_busy", 32'(busy), 32'd1);
        check("f_ack_early", 32'(bus.if_ack), 32'd0);
        tick();
        check("f_ack", 32'(bus.if_ack), 32'd1);
        check("f_rdata", 32'(bus.if_rdata), 32'h1234);
        check("f_read_n_done", 32'(bus.mem_read_n), 32'd1);
        bus.if_req = 1'b0;
        tick();
        check("f_ack_drop", 32'(bus.if_ack), 32'd0);
        check("f_busy_drop", 32'(busy), 32'd0);

        // Data write then back-to-back read of the same address
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 6'd10;
        bus.d_wdata = 16'hBEEF;
        tick();
        check("w_write_n", 32'(bus.mem_write_n), 32'd0);
        check("w_read_n", 32'(bus.mem_read_n), 32'd1);
        check("w_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        check("w_addr", 32'(bus.mem_addr), 32'd10);
        tick();
        check("w_ack", 32'(bus.d_ack), 32'd1);
        check("w_rdata_hold", 32'(bus.d_rdata), 32'd0);
        check("w_write_n_done", 32'(bus.mem_write_n), 32'd1);
        bus.d_we = 1'b0;
        tick();
        check("r_idle_ack", 32'(bus.d_ack), 32'd0);
        check("r_idle_busy", 32'(busy), 32'd0);
        tick();
        check("r_read_n", 32'(bus.mem_read_n), 32'd0);
        check("r_addr", 32'(bus.mem_addr), 32'd10);
        tick();
        check("r_ack", 32'(bus.d_ack), 32'd1);
        check("r_rdata", 32'(bus.d_rdata), 32'hBEEF);
        check("r_if_rdata_hold", 32'(bus.if_rdata), 32'h1234);
        bus.d_req = 1'b0;
        tick();

        // Contention from reset: simultaneous first request, held continuously
        proc_rst = 1'b1;
        tick();
        proc_rst    = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd5;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 6'd10;
        for (int i = 0; i < 10; i++) begin
            wait_ack(is_d, is_f);
            check($sformatf("grant_%0d_is_data", i), 32'(is_d), 32'(exp_d[i]));
            check($sformatf("grant_%0d_is_fetch", i), 32'(is_f), 32'(!exp_d[i]));
            if (exp_d[i])
                check($sformatf("grant_%0d_d_rdata", i), 32'(bus.d_rdata), 32'hBEEF);
            else
                check($sformatf("grant_%0d_if_rdata", i), 32'(bus.if_rdata), 32'h1234);
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Async reset in the middle of a write ACCESS, fetch left pending
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 6'd20;
        bus.d_wdata = 16'h5555;
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd5;
        tick();
        check("ra_write_n_low", 32'(bus.mem_write_n), 32'd0);
        #1;
        proc_rst = 1'b1;
        #1;
        check("ra_write_n_high", 32'(bus.mem_write_n), 32'd1);
        check("ra_read_n_high", 32'(bus.mem_read_n), 32'd1);
        check("ra_busy", 32'(busy), 32'd0);
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check("ra_no_ack", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        proc_rst = 1'b0;
        wait_ack(is_d, is_f);
        check("ra_fetch_served", 32'(is_f), 32'd1);
        check("ra_fetch_rdata", 32'(bus.if_rdata), 32'h1234);
        bus.if_req = 1'b0;
        tick();

        // Idle: nothing requested for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_strobes", 32'({bus.mem_write_n, bus.mem_read_n}), 32'd3);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
            check("idle_if_rdata", 32'(bus.if_rdata), 32'h1234);
            check("idle_d_rdata", 32'(bus.d_rdata), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the processor's single-port 64x16 unified memory.
- The memory has active-low write/read strobes and acts on the falling clock edge.
- Shares the memory between the instruction-fetch unit (read-only) and the data unit (LW/SW/LM/SM traffic).
- Data accesses have fixed priority, with a bounded-burst anti-starvation rule for fetch.
- Drives the memory's address, data-in and strobes; returns registered read data with a one-cycle ack per port.

Parameters:
ADDR_W, 6, memory word-address width
DATA_W, 16, memory word width
BURST_LIMIT, 4, max consecutive data grants while fetch is pending (legal 1..15)

Ports:
clk  input  1  system clock; arbiter logic on rising edge
proc_rst  input  1  asynchronous reset, active-high
if_req  input  1  fetch request; held high until if_ack
if_addr  input  ADDR_W  fetch address; stable while if_req high
if_ack  output  1  one-cycle pulse; if_rdata valid in same cycle
if_rdata  output  DATA_W  fetched word
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = write, 0 = read; stable while d_req high
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_ack  output  1  one-cycle pulse on completion (read or write)
d_rdata  output  DATA_W  read word (reads only)
mem_addr  output  ADDR_W  to memory address
mem_wdata  output  DATA_W  to memory in
mem_write_n  output  1  active-low write strobe to memory
mem_read_n  output  1  active-low read strobe to memory
mem_rdata  input  DATA_W  from memory out (updated on falling edge)
busy  output  1  high when state is not IDLE

Behaviour:
- Reset (async, immediate on proc_rst high):
  - state=IDLE; mem_write_n=1 and mem_read_n=1 (no strobe may glitch low during reset).
  - if_ack=d_ack=0; if_rdata=d_rdata=0; mem_addr=0; mem_wdata=0; burst count=0; busy=0.
- States: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - On a rising edge with any req high, latch the winner's addr (plus wdata/we for data) into mem_addr/mem_wdata.
  - Drive exactly one strobe low: write_n for a data write, read_n for any read. Go to ACCESS.
  - With no req, stay in IDLE with strobes high.
- ACCESS (one cycle): strobe stays low across the falling edge; the memory performs the access.
  - Next rising edge: capture mem_rdata into the winner's rdata (reads only), raise both strobes, pulse the winner's ack, go to DONE.
- DONE (one cycle): ack high. Next edge: ack low, go to IDLE.
- Latency: req seen at edge N -> ack high in cycle N+2..N+3. Throughput: one access per 3 cycles.
- Any req sampled in IDLE is a new transaction. A requester holding req through its ack cycle gets a back-to-back access with its current address.
- The non-winning rdata holds its previous value. d_rdata is unchanged by writes.
- Arbitration (evaluated in IDLE only):
  - Only one req high -> that port wins.
  - Both high -> data wins, unless burst count == BURST_LIMIT, in which case fetch wins.
- Burst count:
  - Increments on each data grant made while if_req is high, saturating at BURST_LIMIT.
  - Clears to 0 on any fetch grant, and on any data grant made with if_req low.
- Requests arriving in ACCESS/DONE are ignored until IDLE; reqs are level-held, so nothing is lost.
- Reset mid-ACCESS aborts: strobes return high immediately. A write may or may not have landed; no ack is issued.
- mem_write_n and mem_read_n are never low together.

Test Plan:
- Fetch only: if_req=1, if_addr=5, mem[5]=16'h1234 -> read_n low one cycle, if_ack pulse 2 edges after req sampled, if_rdata=16'h1234, write_n stays 1.
- Data write then read: d_we=1, d_addr=10, d_wdata=16'hBEEF; on ack, d_we=0 same address -> write_n low one cycle, then d_rdata=16'hBEEF on second d_ack.
- Contention: if_req and d_req held continuously, BURST_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; fetch never waits more than 4 data accesses.
- Simultaneous first request from both ports after reset -> data granted first, fetch next; d_ack and if_ack are never high in the same cycle.
- Async reset asserted mid-ACCESS of a write -> write_n=1 and busy=0 immediately, no ack; after release, a pending if_req is served normally.
- Idle: no reqs for 20 cycles -> both strobes stay 1, busy=0, acks 0, rdata registers unchanged.
